axi_rd_sched: RTL and testbench
===============================

// Module: axi_rd_sched
// PURPOSE
//  Shares the single AXI read channel (AR/R) between the I-cache and D-cache refill/uncached-read ports.
//  Arbitrates rd_req, registers and holds the AR beat, and routes R beats to the owning cache until rlast.
//  Sits between both cache instances and the AXI master, beside the write path, whose idle flag gates new reads.
// PARAMETERS
//  I_BYTES_PER_LINE  16  I-cache line size; burst arlen = I_BYTES_PER_LINE/4-1
//  D_BYTES_PER_LINE  16  D-cache line size; burst arlen = D_BYTES_PER_LINE/4-1
//  STARVE_LIMIT      4   consecutive D grants while I waits before I is forced (fixed-priority mode)
// PORTS
//  clk           in   1   clock
//  reset         in   1   synchronous, active-high
//  wr_idle       in   1   write path idle; new AR granted only when high
//  i_rd_req      in   1   I-cache read request, held until i_rd_rdy
//  i_rd_addr     in   32  I-cache read address
//  i_rd_size     in   2   I-cache single-beat size (log2 bytes)
//  i_burst       in   1   1 = full line INCR burst, 0 = single FIXED beat
//  i_rd_rdy      out  1   AR accepted for I (pulse)
//  i_ret_valid   out  1   R beat for I
//  i_ret_last    out  1   last R beat for I
//  d_rd_req/d_rd_addr/d_rd_size/d_burst/d_rd_rdy/d_ret_valid/d_ret_last  same as i_*, D-cache
//  ret_data      out  32  rdata passthrough, shared by both caches
//  arid out 4, araddr out 32, arlen out 8, arsize out 3, arburst out 2, arvalid out 1, arready in 1
//  rid in 4, rdata in 32, rresp in 2, rlast in 1, rvalid in 1, rready out 1
//  rd_err        out  1   sticky: rresp!=0, rid mismatch, or rlast at wrong beat
// BEHAVIOUR
//  Reset: state IDLE; arvalid, rd_rdy, ret_valid, ret_last, rd_err = 0; AR regs = 0; starve cnt = 0; rready = 1 always.
//  FSM IDLE -> AR -> R -> IDLE.
//  IDLE: if wr_idle & (i_rd_req|d_rd_req): grant one, latch addr/size/burst/owner into AR regs, go AR.
//    Grant: D before I; I forced when starve cnt == STARVE_LIMIT. cnt++ on D grant while i_rd_req high,
//    cleared on I grant or i_rd_req low.
//  AR: arvalid=1, registered; AR fields stable until arready. arvalid first high 1 cycle after grant.
//    arid = 0 (I) / 1 (D). burst: arsize=3'b010, arburst=INCR(01), arlen=line words-1.
//    single: arsize={1'b0,size}, arburst=FIXED(00), arlen=0.
//    arvalid&arready: x_rd_rdy=1 that same cycle (combinational), beat cnt cleared, go R.
//  R: x_ret_valid = rvalid for owner only; x_ret_last = rvalid&rlast; other port 0.
//    Each rvalid beat: beat cnt++. rvalid&rlast -> IDLE; next arvalid no earlier than 2 cycles later.
//  rd_err set (sticky until reset) on rvalid with rresp!=0, rid!=owner id, rlast at beat!=arlen,
//    or beat cnt > arlen without rlast; transfer still routed/completed normally.
//  rvalid in IDLE/AR: ignored, rd_err set.
//  Requester drops rd_req during AR: AR not withdrawn; completes, beats routed to latched owner.
//  wr_idle only sampled in IDLE; a falling wr_idle during AR/R has no effect.
//  Both requests in same IDLE cycle: only one granted; loser waits, req held.
//  Reset mid-operation: immediate return to IDLE, outputs at reset values next cycle; in-flight beats not tracked.
// CONFIGURATION
//  ARB_ROUND_ROBIN_EN defined: grant alternates; requester not granted last wins a tie; starve counter
//    and STARVE_LIMIT unused.
//  Not defined: fixed D-first priority with STARVE_LIMIT anti-starvation as above.
// TESTING
//  D burst 0x1000, wr_idle=1 -> arvalid next cycle, arlen=3, arsize=2, arburst=1, arid=1; 4 beats to d_*, last on beat 4.
//  I single 0x2004 size=1 -> arlen=0, arsize=1, arburst=0; arready delayed 3 cycles, fields stable, i_rd_rdy on accept.
//  I and D held continuously, fixed mode, limit 4 -> grants D,D,D,D,I,D...; RR mode -> alternating I/D.
//  wr_idle=0 with pending req -> arvalid stays 0; wr_idle rises -> arvalid next cycle.
//  Burst with rlast on beat 3, or rresp=2'b10 -> rd_err=1, stays 1, FSM back to IDLE.
//  reset asserted in R state mid-burst -> arvalid, ret_valid, rd_err 0; next request granted normally.

Source files
------------

// File: rtl/axi_rd_sched.sv
// axi_rd_sched: shares one AXI read channel (AR/R) between the I-cache and
// D-cache read ports. One request is granted at a time. Its AR beat is
// registered and held until arready, and its R beats are routed back to the
// owning cache until rlast.
// Optional build macro ARB_ROUND_ROBIN_EN: alternating arbitration. When it
// is undefined, D-cache has priority and an anti-starvation counter forces an
// I grant after STARVE_LIMIT consecutive D grants.
module axi_rd_sched #(
   parameter int I_BYTES_PER_LINE = 16,
   parameter int D_BYTES_PER_LINE = 16,
   parameter int STARVE_LIMIT     = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        wr_idle,
   input  logic        i_rd_req,
   input  logic [31:0] i_rd_addr,
   input  logic [1:0]  i_rd_size,
   input  logic        i_burst,
   output logic        i_rd_rdy,
   output logic        i_ret_valid,
   output logic        i_ret_last,
   input  logic        d_rd_req,
   input  logic [31:0] d_rd_addr,
   input  logic [1:0]  d_rd_size,
   input  logic        d_burst,
   output logic        d_rd_rdy,
   output logic        d_ret_valid,
   output logic        d_ret_last,
   output logic [31:0] ret_data,
   output logic [3:0]  arid,
   output logic [31:0] araddr,
   output logic [7:0]  arlen,
   output logic [2:0]  arsize,
   output logic [1:0]  arburst,
   output logic        arvalid,
   input  logic        arready,
   input  logic [3:0]  rid,
   input  logic [31:0] rdata,
   input  logic [1:0]  rresp,
   input  logic        rlast,
   input  logic        rvalid,
   output logic        rready,
   output logic        rd_err
);

   localparam logic [7:0] I_LINE_LEN = 8'(I_BYTES_PER_LINE / 4 - 1);
   localparam logic [7:0] D_LINE_LEN = 8'(D_BYTES_PER_LINE / 4 - 1);

   typedef enum logic [1:0] {S_IDLE, S_AR, S_R} state_t;

   state_t      state_q, state_d;
   logic        owner_q, owner_d;      // 0 = I-cache, 1 = D-cache
   logic [31:0] addr_q,  addr_d;
   logic [7:0]  len_q,   len_d;
   logic [2:0]  size_q,  size_d;
   logic [1:0]  burst_q, burst_d;
   logic [8:0]  beat_q,  beat_d;       // one bit wider than arlen so overrun is visible
   logic        err_q,   err_d;
   logic        gnt_i,   gnt_d;
   logic [3:0]  own_id;
   logic [8:0]  len_ext;

`ifdef ARB_ROUND_ROBIN_EN
   logic        last_d_q, last_d_d;    // 1 when the most recent grant went to D
`else
   localparam logic [7:0] STARVE_MAX = 8'(STARVE_LIMIT);
   logic [7:0]  starve_q, starve_d;
`endif

   assign own_id  = {3'b000, owner_q};
   assign len_ext = {1'b0, len_q};

   // Arbitration: decide which requester (if any) wins this IDLE cycle
   always_comb begin
      gnt_i = 1'b0;
      gnt_d = 1'b0;
      if (state_q == S_IDLE && wr_idle) begin
`ifdef ARB_ROUND_ROBIN_EN
         if (i_rd_req && d_rd_req) begin
            gnt_i = last_d_q;
            gnt_d = ~last_d_q;
         end else begin
            gnt_i = i_rd_req;
            gnt_d = d_rd_req;
         end
`else
         if (i_rd_req && (starve_q == STARVE_MAX || !d_rd_req)) begin
            gnt_i = 1'b1;
         end else begin
            gnt_d = d_rd_req;
         end
`endif
      end
   end

   // Next-state logic: FSM, AR field capture, beat counting and error detection
   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      addr_d  = addr_q;
      len_d   = len_q;
      size_d  = size_q;
      burst_d = burst_q;
      beat_d  = beat_q;
      err_d   = err_q;
`ifdef ARB_ROUND_ROBIN_EN
      last_d_d = last_d_q;
      if (gnt_i) begin
         last_d_d = 1'b0;
      end else if (gnt_d) begin
         last_d_d = 1'b1;
      end
`else
      starve_d = starve_q;
      if (!i_rd_req || gnt_i) begin
         starve_d = 8'd0;
      end else if (gnt_d && starve_q != 8'hFF) begin
         starve_d = starve_q + 8'd1;
      end
`endif

      case (state_q)
         S_IDLE: begin
            if (gnt_i) begin
               state_d = S_AR;
               owner_d = 1'b0;
               addr_d  = i_rd_addr;
               if (i_burst) begin
                  len_d   = I_LINE_LEN;
                  size_d  = 3'b010;
                  burst_d = 2'b01;
               end else begin
                  len_d   = 8'd0;
                  size_d  = {1'b0, i_rd_size};
                  burst_d = 2'b00;
               end
            end else if (gnt_d) begin
               state_d = S_AR;
               owner_d = 1'b1;
               addr_d  = d_rd_addr;
               if (d_burst) begin
                  len_d   = D_LINE_LEN;
                  size_d  = 3'b010;
                  burst_d = 2'b01;
               end else begin
                  len_d   = 8'd0;
                  size_d  = {1'b0, d_rd_size};
                  burst_d = 2'b00;
               end
            end
         end
         S_AR: begin
            if (arready) begin
               state_d = S_R;
               beat_d  = 9'd0;
            end
         end
         S_R: begin
            if (rvalid) begin
               if (beat_q != 9'h1FF) begin
                  beat_d = beat_q + 9'd1;
               end
               if (rlast) begin
                  state_d = S_IDLE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      // A beat outside R, a bad response/ID, or rlast disagreeing with arlen
      // is flagged; the beat itself is still routed so the transfer completes.
      if (rvalid) begin
         if (state_q != S_R) begin
            err_d = 1'b1;
         end else if (rresp != 2'b00 || rid != own_id ||
                      (rlast && beat_q != len_ext) ||
                      (!rlast && beat_q >= len_ext)) begin
            err_d = 1'b1;
         end
      end
   end

   // State and AR register update with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         owner_q  <= 1'b0;
         addr_q   <= 32'd0;
         len_q    <= 8'd0;
         size_q   <= 3'd0;
         burst_q  <= 2'd0;
         beat_q   <= 9'd0;
         err_q    <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
         last_d_q <= 1'b0;
`else
         starve_q <= 8'd0;
`endif
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         addr_q   <= addr_d;
         len_q    <= len_d;
         size_q   <= size_d;
         burst_q  <= burst_d;
         beat_q   <= beat_d;
         err_q    <= err_d;
`ifdef ARB_ROUND_ROBIN_EN
         last_d_q <= last_d_d;
`else
         starve_q <= starve_d;
`endif
      end
   end

   assign arvalid     = (state_q == S_AR);
   assign arid        = own_id;
   assign araddr      = addr_q;
   assign arlen       = len_q;
   assign arsize      = size_q;
   assign arburst     = burst_q;
   assign i_rd_rdy    = arvalid & arready & ~owner_q;
   assign d_rd_rdy    = arvalid & arready &  owner_q;
   assign i_ret_valid = (state_q == S_R) & rvalid & ~owner_q;
   assign d_ret_valid = (state_q == S_R) & rvalid &  owner_q;
   assign i_ret_last  = i_ret_valid & rlast;
   assign d_ret_last  = d_ret_valid & rlast;
   assign ret_data    = rdata;
   assign rready      = 1'b1;
   assign rd_err      = err_q;

endmodule

// File: tb/tb_axi_rd_sched.sv
// Bench for axi_rd_sched: directed stimulus pushes expected AR beats and R
// returns into queues; a negedge monitor pops and compares them whenever the
// DUT completes an AR handshake or presents a returned beat.
module tb_axi_rd_sched;

   logic        clk = 1'b0;
   logic        reset;
   logic        wr_idle;
   logic        i_rd_req, d_rd_req;
   logic [31:0] i_rd_addr, d_rd_addr;
   logic [1:0]  i_rd_size, d_rd_size;
   logic        i_burst, d_burst;
   logic        i_rd_rdy, d_rd_rdy;
   logic        i_ret_valid, i_ret_last, d_ret_valid, d_ret_last;
   logic [31:0] ret_data;
   logic [3:0]  arid;
   logic [31:0] araddr;
   logic [7:0]  arlen;
   logic [2:0]  arsize;
   logic [1:0]  arburst;
   logic        arvalid, arready;
   logic [3:0]  rid;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rlast, rvalid, rready;
   logic        rd_err;

   typedef struct packed {
      logic [3:0]  id;
      logic [31:0] addr;
      logic [7:0]  len;
      logic [2:0]  size;
      logic [1:0]  burst;
   } ar_t;

   typedef struct packed {
      logic [1:0]  vld;    // {i, d}
      logic        last;
      logic [31:0] data;
   } ret_t;

   ar_t  ar_exp_q[$];
   ret_t ret_exp_q[$];
   ar_t  mon_ar;
   ret_t mon_ret;
   int   checks = 0;
   int   errors = 0;

   axi_rd_sched dut (
      .clk(clk), .reset(reset), .wr_idle(wr_idle),
      .i_rd_req(i_rd_req), .i_rd_addr(i_rd_addr), .i_rd_size(i_rd_size), .i_burst(i_burst),
      .i_rd_rdy(i_rd_rdy), .i_ret_valid(i_ret_valid), .i_ret_last(i_ret_last),
      .d_rd_req(d_rd_req), .d_rd_addr(d_rd_addr), .d_rd_size(d_rd_size), .d_burst(d_burst),
      .d_rd_rdy(d_rd_rdy), .d_ret_valid(d_ret_valid), .d_ret_last(d_ret_last),
      .ret_data(ret_data),
      .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
      .arvalid(arvalid), .arready(arready),
      .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
      .rd_err(rd_err)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   function automatic ar_t mk_ar(input logic [3:0] id, input logic [31:0] addr,
                                 input logic [7:0] len, input logic [2:0] size,
                                 input logic [1:0] burst);
      ar_t a;
      a.id = id; a.addr = addr; a.len = len; a.size = size; a.burst = burst;
      return a;
   endfunction

   task automatic exp_beats(input logic [1:0] vld, input int n, input int lastk, input logic [31:0] base);
      ret_t r;
      for (int k = 0; k < n; k++) begin
         r.vld = vld; r.last = (k == lastk); r.data = base + 32'(k);
         ret_exp_q.push_back(r);
      end
   endtask

   task automatic wait_ar();
      int n = 0;
      while (!arvalid && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      if (!arvalid) begin
         checks++;
         errors++;
         $display("FAIL ar_timeout: arvalid got 0, expected 1 within 20 cycles");
      end
   endtask

   // Hold arready low for dly cycles, checking the AR beat stays put, then accept it
   task automatic accept(input int dly);
      logic [49:0] snap;
      snap = {arvalid, arid, araddr, arlen, arsize, arburst};
      for (int k = 0; k < dly; k++) begin
         @(posedge clk); #1;
         chk("ar_stable", {14'd0, arvalid, arid, araddr, arlen, arsize, arburst}, {14'd0, snap});
         chk("rdy_while_wait", {62'd0, i_rd_rdy, d_rd_rdy}, 64'd0);
      end
      arready = 1'b1;
      @(posedge clk); #1;
      arready = 1'b0;
   endtask

   task automatic send_beats(input logic [3:0] id, input int n, input int lastk,
                             input int badk, input logic [31:0] base);
      for (int k = 0; k < n; k++) begin
         rvalid = 1'b1;
         rid    = id;
         rdata  = base + 32'(k);
         rlast  = (k == lastk);
         rresp  = (k == badk) ? 2'b10 : 2'b00;
         @(posedge clk); #1;
      end
      rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
   endtask

   // Monitor: compare every AR handshake and every returned beat against the queues
   always @(negedge clk) begin
      if (!reset) begin
         if (arvalid && arready) begin
            if (ar_exp_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL ar_unexpected: got handshake addr %h, expected none", araddr);
            end else begin
               mon_ar = ar_exp_q.pop_front();
               chk("ar_fields", {15'd0, arid, araddr, arlen, arsize, arburst}, {15'd0, mon_ar});
               chk("rd_rdy", {62'd0, i_rd_rdy, d_rd_rdy},
                   {62'd0, (mon_ar.id == 4'd0) ? 2'b10 : 2'b01});
            end
         end
         if (i_ret_valid || d_ret_valid) begin
            if (ret_exp_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL ret_unexpected: got beat %h, expected none", ret_data);
            end else begin
               mon_ret = ret_exp_q.pop_front();
               chk("ret_beat", {28'd0, i_ret_valid, d_ret_valid, i_ret_last, d_ret_last, ret_data},
                   {28'd0, mon_ret.vld, mon_ret.last ? mon_ret.vld : 2'b00, mon_ret.data});
            end
         end
      end
   end

   logic [3:0] seq [6];

   initial begin
      reset = 1'b1; wr_idle = 1'b1;
      i_rd_req = 0; i_rd_addr = 0; i_rd_size = 0; i_burst = 0;
      d_rd_req = 0; d_rd_addr = 0; d_rd_size = 0; d_burst = 0;
      arready = 0; rid = 0; rdata = 0; rresp = 0; rlast = 0; rvalid = 0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_arvalid", {63'd0, arvalid}, 64'd0);
      chk("rst_rdy", {62'd0, i_rd_rdy, d_rd_rdy}, 64'd0);
      chk("rst_ret", {60'd0, i_ret_valid, d_ret_valid, i_ret_last, d_ret_last}, 64'd0);
      chk("rst_err", {63'd0, rd_err}, 64'd0);
      chk("rst_arregs", {15'd0, arid, araddr, arlen, arsize, arburst}, 64'd0);
      chk("rready", {63'd0, rready}, 64'd1);
      reset = 1'b0;

      // D line burst at 0x1000
      ar_exp_q.push_back(mk_ar(4'd1, 32'h1000, 8'd3, 3'd2, 2'd1));
      exp_beats(2'b01, 4, 3, 32'hA0);
      d_rd_addr = 32'h1000; d_rd_size = 2'd2; d_burst = 1'b1; d_rd_req = 1'b1;
      @(posedge clk); #1;
      chk("d_arvalid_next", {63'd0, arvalid}, 64'd1);
      accept(0);
      d_rd_req = 1'b0;
      send_beats(4'd1, 4, 3, -1, 32'hA0);
      chk("d_burst_err", {63'd0, rd_err}, 64'd0);

      // I single beat, arready delayed 3 cycles
      ar_exp_q.push_back(mk_ar(4'd0, 32'h2004, 8'd0, 3'd1, 2'd0));
      exp_beats(2'b10, 1, 0, 32'hB0);
      i_rd_addr = 32'h2004; i_rd_size = 2'd1; i_burst = 1'b0; i_rd_req = 1'b1;
      wait_ar();
      accept(3);
      i_rd_req = 1'b0;
      chk("i_rdy_pulse", {63'd0, i_rd_rdy}, 64'd0);
      send_beats(4'd0, 1, 0, -1, 32'hB0);

      // wr_idle low blocks the grant
      wr_idle = 1'b0;
      ar_exp_q.push_back(mk_ar(4'd1, 32'h5008, 8'd0, 3'd0, 2'd0));
      exp_beats(2'b01, 1, 0, 32'hE0);
      d_rd_addr = 32'h5008; d_rd_size = 2'd0; d_burst = 1'b0; d_rd_req = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(posedge clk); #1;
         chk("wr_busy_arvalid", {63'd0, arvalid}, 64'd0);
      end
      wr_idle = 1'b1;
      @(posedge clk); #1;
      chk("wr_idle_arvalid", {63'd0, arvalid}, 64'd1);
      accept(0);
      d_rd_req = 1'b0;
      send_beats(4'd1, 1, 0, -1, 32'hE0);

      // rlast on beat 3 of a 4-beat burst
      ar_exp_q.push_back(mk_ar(4'd1, 32'h6000, 8'd3, 3'd2, 2'd1));
      exp_beats(2'b01, 3, 2, 32'hF0);
      d_rd_addr = 32'h6000; d_burst = 1'b1; d_rd_req = 1'b1;
      wait_ar();
      accept(0);
      d_rd_req = 1'b0;
      send_beats(4'd1, 3, 2, -1, 32'hF0);
      chk("early_last_err", {63'd0, rd_err}, 64'd1);
      repeat (3) @(posedge clk);
      #1;
      chk("err_sticky", {63'd0, rd_err}, 64'd1);
      chk("idle_after_err", {63'd0, arvalid}, 64'd0);

      // Reset in the middle of a burst
      ar_exp_q.push_back(mk_ar(4'd1, 32'h7000, 8'd3, 3'd2, 2'd1));
      exp_beats(2'b01, 2, -1, 32'hD0);
      d_rd_addr = 32'h7000; d_rd_req = 1'b1;
      wait_ar();
      accept(0);
      d_rd_req = 1'b0;
      send_beats(4'd1, 2, -1, -1, 32'hD0);
      reset = 1'b1;
      rvalid = 1'b1; rid = 4'd1; rdata = 32'hD2;
      @(posedge clk); #1;
      chk("midrst_arvalid", {63'd0, arvalid}, 64'd0);
      chk("midrst_ret", {62'd0, i_ret_valid, d_ret_valid}, 64'd0);
      chk("midrst_err", {63'd0, rd_err}, 64'd0);
      rvalid = 1'b0;
      reset = 1'b0;

      // I line burst after reset, with rresp error on beat 2
      ar_exp_q.push_back(mk_ar(4'd0, 32'h8000, 8'd3, 3'd2, 2'd1));
      exp_beats(2'b10, 4, 3, 32'h80);
      i_rd_addr = 32'h8000; i_burst = 1'b1; i_rd_req = 1'b1;
      wait_ar();
      accept(0);
      i_rd_req = 1'b0;
      send_beats(4'd0, 4, 3, 1, 32'h80);
      chk("rresp_err", {63'd0, rd_err}, 64'd1);
      @(posedge clk); #1;
      chk("rresp_idle", {63'd0, arvalid}, 64'd0);

      // Both requesters held: grant order
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      seq = '{4'd1, 4'd0, 4'd1, 4'd0, 4'd1, 4'd0};
`else
      seq = '{4'd1, 4'd1, 4'd1, 4'd1, 4'd0, 4'd1};
`endif
      for (int t = 0; t < 6; t++) begin
         if (seq[t] == 4'd0) begin
            ar_exp_q.push_back(mk_ar(4'd0, 32'h3000, 8'd0, 3'd2, 2'd0));
            exp_beats(2'b10, 1, 0, 32'hC0 + 32'(t));
         end else begin
            ar_exp_q.push_back(mk_ar(4'd1, 32'h4000, 8'd0, 3'd2, 2'd0));
            exp_beats(2'b01, 1, 0, 32'hC0 + 32'(t));
         end
      end
      i_rd_addr = 32'h3000; i_rd_size = 2'd2; i_burst = 1'b0;
      d_rd_addr = 32'h4000; d_rd_size = 2'd2; d_burst = 1'b0;
      i_rd_req = 1'b1; d_rd_req = 1'b1;
      for (int t = 0; t < 6; t++) begin
         wait_ar();
         accept(0);
         if (t == 5) begin
            i_rd_req = 1'b0; d_rd_req = 1'b0;
         end
         send_beats(seq[t], 1, 0, -1, 32'hC0 + 32'(t));
      end
      repeat (3) @(posedge clk);
      #1;
      chk("grant_err", {63'd0, rd_err}, 64'd0);
      chk("ar_queue_empty", 64'(ar_exp_q.size()), 64'd0);
      chk("ret_queue_empty", 64'(ret_exp_q.size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
